// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down-counter: default width and the
// two-state encoding also used by the up-counter.
package down_counter_pkg;

   localparam int unsigned DEF_WIDTH = 9;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/down_counter_if.sv
// Control/data bundle between the timer and its user: load/enable/reload
// controls in, count, terminal-count pulse and busy out.
interface down_counter_if
   import down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) ();

   logic             load;
   logic             enab;
   logic             auto_reload;
   logic [WIDTH-1:0] cnt_in;
   logic [WIDTH-1:0] cnt_out;
   logic             tc;
   logic             busy;

   modport master (
      output load,
      output enab,
      output auto_reload,
      output cnt_in,
      input  cnt_out,
      input  tc,
      input  busy
   );

   modport slave (
      input  load,
      input  enab,
      input  auto_reload,
      input  cnt_in,
      output cnt_out,
      output tc,
      output busy
   );

endinterface

// File: rtl/down_counter.sv
// Loadable down-counter / interval timer with one-cycle terminal-count pulse
// and optional auto-reload from the last loaded value.
module down_counter
   import down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input logic           clk,
   input logic           rst_n,
   down_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      tc_d     = 1'b0;

      if (bus.load) begin
         cnt_d    = bus.cnt_in;
         reload_d = bus.cnt_in;
         state_d  = (bus.cnt_in != '0) ? ST_RUN : ST_IDLE;
      end else if (bus.enab && state_q == ST_RUN) begin
         // RUN guarantees cnt_q >= 1, so the decrement below cannot underflow
         if (cnt_q > ONE) begin
            cnt_d = cnt_q - ONE;
         end else begin
            tc_d = 1'b1;
            if (bus.auto_reload) begin
               cnt_d = reload_q;
            end else begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   assign bus.cnt_out = cnt_q;
   assign bus.tc      = tc_q;
   assign bus.busy    = (state_q == ST_RUN);

endmodule
